// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with grant hold and timeout pre-emption.
// Registered grant index, valid flag and one-cycle preempt pulse.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] req,
    input  logic       done,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    localparam logic          TMO_EN   = (MAX_HOLD != 0);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e        state;
    logic [2:0]    ptr;
    logic [HW-1:0] hold_cnt;

    logic [2:0] win;
    logic [2:0] cand;
    logic       hit;

    // Search starts just after ptr, so the last holder ranks last.
    always_comb begin
        win  = ptr;
        cand = ptr;
        hit  = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            cand = ptr + 3'(k);
            if (!hit && req[cand]) begin
                hit = 1'b1;
                win = cand;
            end
        end
    end

    logic holder_req;
    logic tmo;
    logic rel;
    logic pre_nxt;

    always_comb begin
        holder_req = req[gnt_idx];
        tmo        = TMO_EN && (hold_cnt == HOLD_LIM);
        rel        = done || !holder_req || tmo;
        pre_nxt    = !done && holder_req && tmo;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            hold_cnt  <= '0;
            gnt_idx   <= 3'd0;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    preempt <= 1'b0;
                    if (hit) begin
                        state     <= GRANT;
                        gnt_idx   <= win;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= HOLD_ONE;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        state     <= IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx;
                        preempt   <= pre_nxt;
                        hold_cnt  <= '0;
                    end else begin
                        preempt <= 1'b0;
                        if (TMO_EN && hold_cnt != HOLD_LIM)
                            hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Bench for rr_arbiter_8: directed scenarios plus random traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_rr_arbiter_8;

    localparam int MAXH = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Model: who owns the resource, who owned it last, how long held.
    bit m_busy;
    bit m_pre;
    int m_owner;
    int m_last;
    int m_held;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic void m_reset();
        m_busy  = 0;
        m_pre   = 0;
        m_owner = 0;
        m_last  = 7;
        m_held  = 0;
    endfunction

    function automatic void m_end(bit timed_out);
        m_busy = 0;
        m_last = m_owner;
        m_pre  = timed_out;
        m_held = 0;
    endfunction

    function automatic void m_step(input logic [7:0] r, input logic d);
        if (!m_busy) begin
            m_pre = 0;
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last + k) % 8;
                if (!m_busy && r[c]) begin
                    m_busy  = 1;
                    m_owner = c;
                    m_held  = 1;
                end
            end
        end else if (d) begin
            m_end(0);
        end else if (!r[m_owner]) begin
            m_end(0);
        end else if (MAXH != 0 && m_held >= MAXH) begin
            m_end(1);
        end else begin
            m_pre  = 0;
            m_held = m_held + 1;
        end
    endfunction

    task automatic compare(input string ctx);
        chk({ctx, "_valid"}, 32'(gnt_valid), 32'(m_busy));
        chk({ctx, "_idx"}, 32'(gnt_idx), 32'(m_owner));
        chk({ctx, "_preempt"}, 32'(preempt), 32'(m_pre));
        if (gnt_valid === 1'b1)
            chk({ctx, "_idx_known"}, 32'($isunknown(gnt_idx)), 32'd0);
    endtask

    task automatic cycle(input logic [7:0] r, input logic d,
                         input string ctx);
        req  = r;
        done = d;
        @(posedge clk);
        if (!reset_n) m_reset();
        else m_step(r, d);
        @(negedge clk);
        compare(ctx);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 8'h00;
        done    = 1'b0;
        m_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        compare("rst");
    endtask

    initial begin
        int vcount;
        int dp;
        logic [7:0] r;
        logic       d;

        m_reset();
        @(negedge clk);
        do_reset();

        // Single requester, done release
        cycle(8'h01, 1'b0, "t1_grant");
        chk("t1_idx0", 32'(gnt_idx), 32'd0);
        cycle(8'h01, 1'b1, "t1_done");
        chk("t1_drop", 32'(gnt_valid), 32'd0);

        // Full request, done every grant: 0..7,0
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cycle(8'hFF, 1'b0, "t2_grant");
            chk("t2_order", 32'(gnt_idx), 32'(i % 8));
            cycle(8'hFF, 1'b1, "t2_rel");
        end

        // Wrap-around from ptr=6
        do_reset();
        cycle(8'h40, 1'b0, "t3_g6");
        cycle(8'h40, 1'b1, "t3_r6");
        cycle(8'h41, 1'b0, "t3_g0");
        chk("t3_wrap0", 32'(gnt_idx), 32'd0);
        cycle(8'h41, 1'b1, "t3_r0");
        cycle(8'h41, 1'b0, "t3_g6b");
        chk("t3_wrap6", 32'(gnt_idx), 32'd6);
        cycle(8'h00, 1'b0, "t3_idle");

        // Timeout pre-emption and re-grant
        do_reset();
        vcount = 0;
        for (int i = 0; i < 17; i++) begin
            cycle(8'h08, 1'b0, "t4_hold");
            if (gnt_valid === 1'b1) vcount++;
        end
        chk("t4_hold_len", 32'(vcount), 32'(MAXH));
        chk("t4_preempt", 32'(preempt), 32'd1);
        cycle(8'h08, 1'b0, "t4_regrant");
        chk("t4_idx3", 32'(gnt_idx), 32'd3);
        chk("t4_pulse", 32'(preempt), 32'd0);

        // Done coincident with timeout counts as done
        do_reset();
        for (int i = 0; i < MAXH; i++)
            cycle(8'h08, 1'b0, "t4b_hold");
        cycle(8'h08, 1'b1, "t4b_both");
        chk("t4b_nopre", 32'(preempt), 32'd0);

        // Holder withdraws, other requester waiting
        do_reset();
        cycle(8'h04, 1'b0, "t5_g2");
        cycle(8'h24, 1'b0, "t5_hold");
        cycle(8'h20, 1'b0, "t5_drop");
        chk("t5_rel", 32'(gnt_valid), 32'd0);
        cycle(8'h20, 1'b0, "t5_g5");
        chk("t5_idx5", 32'(gnt_idx), 32'd5);
        chk("t5_nopre", 32'(preempt), 32'd0);

        // Done while idle is ignored
        cycle(8'h20, 1'b1, "t5_rel5");
        cycle(8'h00, 1'b1, "t5_idle_done");

        // Async reset mid-grant
        do_reset();
        cycle(8'h01, 1'b0, "t6_g0");
        cycle(8'h10, 1'b0, "t6_r0");
        cycle(8'h10, 1'b0, "t6_g4");
        reset_n = 1'b0;
        #1;
        chk("t6_async_drop", 32'(gnt_valid), 32'd0);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        compare("t6_rst");
        cycle(8'h10, 1'b0, "t6_regrant");
        chk("t6_idx4", 32'(gnt_idx), 32'd4);
        cycle(8'h00, 1'b0, "t6_rel");

        // Random traffic in phases of differing done density
        r = 8'h00;
        for (int seg = 0; seg < 60; seg++) begin
            case ($urandom_range(0, 2))
                0: dp = 0;
                1: dp = 5;
                default: dp = 30;
            endcase
            for (int i = 0; i < 50; i++) begin
                if ($urandom_range(0, 7) == 0) begin
                    r = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) r = r & 8'($urandom);
                end
                d = ($urandom_range(0, 99) < dp);
                cycle(r, d, "rnd");
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
